// File: rtl/rename_regfile_if.sv
// Rename register file bus: read ports, rename request and ROB commit write.
//   master : drives indices and requests, receives read results (issue/ROB side)
//   slave  : the register file itself
// rdy_in, clk_in and rst_in are plain ports on the block, not part of this bus.
interface rename_regfile_if #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4
);
    localparam int IDX_W = $clog2(REG_NUM);

    // read ports
    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;

    // destination rename
    logic             rename_en;
    logic [IDX_W-1:0] rename_rd;
    logic [TAG_W-1:0] rename_tag;

    // ROB commit write
    logic             commit_en;
    logic [IDX_W-1:0] commit_rd;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_val;

    // recovery
    logic             flush;

    modport master (
        output rs1_idx, rs2_idx,
        input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val,
        output rename_en, rename_rd, rename_tag,
        output commit_en, commit_rd, commit_tag, commit_val,
        output flush
    );

    modport slave (
        input  rs1_idx, rs2_idx,
        output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val,
        input  rename_en, rename_rd, rename_tag,
        input  commit_en, commit_rd, commit_tag, commit_val,
        input  flush
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with rename (busy/tag) tracking.
// Ports:
//   clk_in  - clock, all state changes on rising edge
//   rst_in  - synchronous active-high reset, clears values, busy bits and tags
//   rdy_in  - global ready; when low, rename/commit/flush are ignored
//   bus     - rename_regfile_if.slave: two combinational read ports with
//             same-cycle commit bypass, rename request, commit write, flush
// Index 0 and indices >= REG_NUM read as zero and ignore writes.
module rename_regfile #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    rename_regfile_if.slave    bus
);
    localparam int IDX_W = $clog2(REG_NUM);
    localparam logic [IDX_W:0] REG_LIM = (IDX_W+1)'(REG_NUM);

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } rd_port_t;

    logic [XLEN-1:0]  val_q  [REG_NUM];
    logic             busy_q [REG_NUM];
    logic [TAG_W-1:0] tag_q  [REG_NUM];

    // Index 0 is hardwired zero; out-of-range indices behave like index 0.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < REG_LIM);
    endfunction

    // A busy register whose producer is committing this very cycle is
    // forwarded as ready with the committing value.
    function automatic rd_port_t read_port(
        input logic [IDX_W-1:0] idx,
        input logic             c_en,
        input logic [IDX_W-1:0] c_rd,
        input logic [TAG_W-1:0] c_tag,
        input logic [XLEN-1:0]  c_val
    );
        rd_port_t r;
        r = '0;
        if (idx_ok(idx)) begin
            if (busy_q[idx]) begin
                if (c_en && (c_rd == idx) && (c_tag == tag_q[idx])) begin
                    r.val = c_val;
                end else begin
                    r.busy = 1'b1;
                    r.tag  = tag_q[idx];
                end
            end else begin
                r.val = val_q[idx];
            end
        end
        return r;
    endfunction

    rd_port_t rs1_r;
    rd_port_t rs2_r;

    // NOTE: every combinational output is given a value on every path (here by
    // the function's default), so no latch can be inferred.
    always_comb begin
        rs1_r = read_port(bus.rs1_idx, bus.commit_en, bus.commit_rd,
                          bus.commit_tag, bus.commit_val);
        rs2_r = read_port(bus.rs2_idx, bus.commit_en, bus.commit_rd,
                          bus.commit_tag, bus.commit_val);
    end

    assign bus.rs1_busy = rs1_r.busy;
    assign bus.rs1_tag  = rs1_r.tag;
    assign bus.rs1_val  = rs1_r.val;
    assign bus.rs2_busy = rs2_r.busy;
    assign bus.rs2_tag  = rs2_r.tag;
    assign bus.rs2_val  = rs2_r.val;

    // NOTE: the storage array is reset explicitly because the block must read
    // all zeros after reset; this costs a reset net per bit, which is accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments to the same entry later in this
            // block take precedence, which gives flush and rename priority over
            // the commit's busy/tag clear while the commit value still lands.
            if (bus.commit_en && idx_ok(bus.commit_rd)) begin
                val_q[bus.commit_rd] <= bus.commit_val;
                if (busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag)) begin
                    busy_q[bus.commit_rd] <= 1'b0;
                    tag_q[bus.commit_rd]  <= '0;
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end else if (bus.rename_en && idx_ok(bus.rename_rd)) begin
                busy_q[bus.rename_rd] <= 1'b1;
                tag_q[bus.rename_rd]  <= bus.rename_tag;
            end
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_rename_regfile;
    localparam int REG_NUM = 32;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 4;
    localparam int IDX_W   = 5;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    rename_regfile_if #(.REG_NUM(REG_NUM), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    rename_regfile #(.REG_NUM(REG_NUM), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0]  m_val  [REG_NUM];
    logic             m_busy [REG_NUM];
    logic [TAG_W-1:0] m_tag  [REG_NUM];

    // expected {busy, tag, val} for a read of idx given the current inputs
    function automatic logic [63:0] exp_read(input logic [IDX_W-1:0] idx);
        if (idx == 0) return 64'd0;
        if (m_busy[idx]) begin
            if (bus.commit_en && bus.commit_rd == idx && bus.commit_tag == m_tag[idx])
                return {27'd0, 1'b0, 4'd0, bus.commit_val};
            return {27'd0, 1'b1, m_tag[idx], 32'd0};
        end
        return {27'd0, 1'b0, 4'd0, m_val[idx]};
    endfunction

    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            logic was_busy;
            logic [TAG_W-1:0] old_tag;
            if (bus.commit_en && bus.commit_rd != 0) begin
                was_busy = m_busy[bus.commit_rd];
                old_tag  = m_tag[bus.commit_rd];
                m_val[bus.commit_rd] = bus.commit_val;
                if (was_busy && old_tag == bus.commit_tag) begin
                    m_busy[bus.commit_rd] = 1'b0;
                    m_tag[bus.commit_rd]  = '0;
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    m_busy[i] = 1'b0; m_tag[i] = '0;
                end
            end else if (bus.rename_en && bus.rename_rd != 0) begin
                m_busy[bus.rename_rd] = 1'b1;
                m_tag[bus.rename_rd]  = bus.rename_tag;
            end
        end
    end

    // compare process: read outputs checked against the model every cycle
    bit cmp_on = 1'b0;
    always @(negedge clk_in) begin
        if (cmp_on) begin
            check("rs1_model", {27'd0, bus.rs1_busy, bus.rs1_tag, bus.rs1_val}, exp_read(bus.rs1_idx));
            check("rs2_model", {27'd0, bus.rs2_busy, bus.rs2_tag, bus.rs2_val}, exp_read(bus.rs2_idx));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.rename_en  = 1'b0; bus.rename_rd = '0; bus.rename_tag = '0;
        bus.commit_en  = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0;
        bus.commit_val = '0;   bus.flush     = 1'b0;
    endtask

    task automatic lit(input string name, input logic b, input logic [TAG_W-1:0] t,
                       input logic [XLEN-1:0] v);
        @(negedge clk_in);
        check(name, {27'd0, bus.rs1_busy, bus.rs1_tag, bus.rs1_val}, {27'd0, b, t, v});
    endtask

    task automatic rename(input int rd, input int tag);
        bus.rename_en = 1'b1; bus.rename_rd = IDX_W'(rd); bus.rename_tag = TAG_W'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] v);
        bus.commit_en = 1'b1; bus.commit_rd = IDX_W'(rd); bus.commit_tag = TAG_W'(tag);
        bus.commit_val = v;
    endtask

    initial begin
        idle();
        rst_in = 1'b1; rdy_in = 1'b1;
        bus.rs1_idx = 5'd5; bus.rs2_idx = 5'd31;
        tick(); tick();
        rst_in = 1'b0;
        cmp_on = 1'b1;
        lit("reset_zero", 1'b0, 4'd0, 32'd0);

        // rename x5 tag 3, read, commit with bypass, persist
        tick(); rename(5, 3);
        tick(); idle(); bus.rs1_idx = 5'd5;
        lit("x5_busy", 1'b1, 4'd3, 32'd0);
        commit(5, 3, 32'hDEAD);
        lit("x5_bypass", 1'b0, 4'd0, 32'hDEAD);
        tick(); idle();
        lit("x5_persist", 1'b0, 4'd0, 32'hDEAD);

        // stale commit on x7
        tick(); rename(7, 2);
        tick(); rename(7, 9);
        tick(); idle(); commit(7, 2, 32'h11);
        tick(); idle(); bus.rs1_idx = 5'd7;
        lit("x7_stale", 1'b1, 4'd9, 32'd0);
        commit(7, 9, 32'h22);
        lit("x7_bypass", 1'b0, 4'd0, 32'h22);
        tick(); idle();
        lit("x7_done", 1'b0, 4'd0, 32'h22);

        // same-cycle rename and commit on x4
        tick(); rename(4, 1);
        tick(); rename(4, 6); commit(4, 1, 32'h44);
        tick(); idle(); bus.rs1_idx = 5'd4;
        lit("x4_rename_wins", 1'b1, 4'd6, 32'd0);
        commit(4, 5, 32'h55);
        tick(); idle();
        lit("x4_stale_kept", 1'b1, 4'd6, 32'd0);
        bus.flush = 1'b1;
        tick(); idle();
        lit("x4_flush_val", 1'b0, 4'd0, 32'h55);

        // rename everything, then flush with a rename of x3
        for (int i = 1; i < REG_NUM; i++) begin
            tick(); rename(i, i % 16);
        end
        tick(); idle(); bus.rs1_idx = 5'd31;
        lit("x31_busy", 1'b1, 4'd15, 32'd0);
        bus.flush = 1'b1; rename(3, 7);
        tick(); idle(); bus.rs1_idx = 5'd3;
        lit("x3_flush_drop", 1'b0, 4'd0, 32'd0);
        tick(); bus.rs1_idx = 5'd5;
        lit("x5_after_flush", 1'b0, 4'd0, 32'hDEAD);

        // x0 writes ignored; rdy_in low blocks rename
        tick(); rename(0, 5); commit(0, 0, 32'hFFFF_FFFF); bus.rs1_idx = 5'd0;
        tick(); idle();
        lit("x0_zero", 1'b0, 4'd0, 32'd0);
        rdy_in = 1'b0; rename(8, 1);
        tick(); idle(); rdy_in = 1'b1; bus.rs1_idx = 5'd8;
        lit("x8_not_ready", 1'b0, 4'd0, 32'd0);

        // reset mid-operation
        tick(); rename(2, 4);
        tick(); rename(2, 5); commit(2, 4, 32'h77); rst_in = 1'b1;
        tick(); idle(); rst_in = 1'b0; bus.rs1_idx = 5'd2;
        lit("x2_reset", 1'b0, 4'd0, 32'd0);
        tick(); bus.rs1_idx = 5'd5;
        lit("x5_reset", 1'b0, 4'd0, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            idle();
            rst_in = ($urandom_range(0, 199) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            bus.rs1_idx = IDX_W'($urandom_range(0, REG_NUM - 1));
            bus.rs2_idx = ($urandom_range(0, 3) == 0) ? bus.rs1_idx
                                                      : IDX_W'($urandom_range(0, REG_NUM - 1));
            if ($urandom_range(0, 1) == 1)
                rename($urandom_range(0, REG_NUM - 1), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                int rd;
                rd = ($urandom_range(0, 1) == 1) ? int'(bus.rs1_idx) : int'($urandom_range(0, REG_NUM - 1));
                commit(rd, ($urandom_range(0, 3) != 0) ? int'(m_tag[rd]) : int'($urandom_range(0, 15)),
                       $urandom);
            end
            bus.flush = ($urandom_range(0, 29) == 0);
        end
        tick();
        idle();
        @(negedge clk_in);
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameter REG_NUM, default 32, is the number of architectural registers; IDX_W = ceil(log2(REG_NUM)).
REQ-002 Parameter XLEN, default 32, is the register data width.
REQ-003 Parameter TAG_W, default 4, is the ROB entry tag width.
REQ-004 clk_in  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 rst_in  input  1  is the synchronous, active-high reset.
REQ-006 rdy_in  input  1  is the global ready; when it is low, all state SHALL hold.
REQ-007 rs1_idx, rs2_idx  input  IDX_W  are the source register indices for read ports 1 and 2.
REQ-008 rs1_busy, rs2_busy  output  1  SHALL be high when the source awaits a pending producer.
REQ-009 rs1_tag, rs2_tag  output  TAG_W  are the producer ROB tag, valid only when busy.
REQ-010 rs1_val, rs2_val  output  XLEN  are the source value, valid only when not busy.
REQ-011 rename_en  input  1, rename_rd  input  IDX_W, rename_tag  input  TAG_W  form the destination rename request.
REQ-012 commit_en  input  1, commit_rd  input  IDX_W, commit_tag  input  TAG_W, commit_val  input  XLEN  form the ROB commit write.
REQ-013 flush  input  1  is the mispredict/exception recovery signal.

Function
REQ-014 The block SHALL hold, per register, a value (XLEN), a busy bit and a tag (TAG_W); tag 0 is a legal tag, and validity is carried only by busy.
REQ-015 Read ports SHALL be combinational with zero latency; both ports are independent and may address the same register.
REQ-016 For a read of a busy register, outputs SHALL be busy=1, tag=stored tag and val=0; for a non-busy register, busy=0, tag=0 and val=stored value.
REQ-017 Commit bypass: if commit_en is high, commit_rd equals rs_idx, the register is busy and commit_tag equals the stored tag, the port SHALL output busy=0, tag=0 and val=commit_val in the same cycle.
REQ-018 Reads SHALL reflect state before the current cycle's rename; the same-cycle rename_rd does not affect rs outputs.
REQ-019 Register index 0 SHALL read as busy=0, tag=0, val=0 always; renames and commits to index 0 SHALL be ignored.
REQ-020 Rename (rename_en, rdy_in, !flush, rd≠0): busy[rd] SHALL be set to 1 and tag[rd] to rename_tag at the next edge.
REQ-021 Commit (commit_en, rdy_in, rd≠0): value[rd] SHALL be set to commit_val unconditionally, and busy[rd]/tag[rd] SHALL be cleared to 0 only if busy and the tag matches.
REQ-022 When a commit with a stale tag (mismatch) occurs, the block SHALL update the value only and leave busy and tag unchanged.
REQ-023 When rename and commit target the same rd in the same cycle, rename SHALL win for busy and tag, and commit still SHALL write the value.
REQ-024 Flush (with rdy_in): all busy and tag entries SHALL be cleared at the next edge, and values SHALL be retained.
REQ-025 A commit in the same cycle as flush SHALL still write its value, and a rename in the same cycle as flush SHALL be dropped.
REQ-026 When rdy_in=0, rename, commit and flush SHALL be ignored, while read outputs remain combinationally valid.
REQ-027 Indices >= REG_NUM (non-power-of-two REG_NUM) SHALL read as REG_NUM index 0 behaviour and writes to them SHALL be ignored.

Reset
REQ-028 When rst_in is high at an edge, it SHALL override rdy_in, flush, rename and commit.
REQ-029 Reset SHALL clear all values, busy bits and tags to 0.
REQ-030 After reset, all read outputs SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending renames, with no partial state retained.

Verification
REQ-032 Rename x5 tag 3, next cycle read rs1=5 -> busy=1, tag=3, val=0; commit x5 tag 3 val 0xDEAD -> same-cycle rs1 busy=0, val=0xDEAD; next cycle value persists.
REQ-033 Rename x7 tag 2 then tag 9; commit x7 tag 2 val 0x11 -> value=0x11, busy=1, tag=9 remain; commit tag 9 val 0x22 -> busy=0, val=0x22.
REQ-034 Same-cycle rename and commit to x4 (busy, tag 1 committing; new tag 6) -> after edge busy=1, tag=6, value=commit_val.
REQ-035 Rename x1..x31 with tags i mod 16, then flush together with a rename of x3 -> all busy=0, x3 not busy, values unchanged.
REQ-036 Rename/commit to x0 with val 0xFFFFFFFF -> rs1=0 reads busy=0, val=0; with rdy_in=0, rename x8 -> x8 stays not busy.
REQ-037 Assert rst_in during a cycle with rename x2 and commit x2 -> all state reads 0 and not busy.
